// File: rtl/set_packer.sv
// Packs IN_WORDS-wide input beats into DATA_OF_SET-word sets for the operand buffer.
// A one-set stage holds the finished set while the next one assembles behind it.

module set_packer_slot #(
  parameter int SLOT       = 0,
  parameter int BW         = 1,
  parameter int IN_WORDS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr,
  input  logic                                 clr,
  input  logic [BW-1:0]                        beat_cnt,
  input  logic [IN_WORDS-1:0][DATA_WIDTH-1:0]  in_data,
  output logic [IN_WORDS-1:0][DATA_WIDTH-1:0]  merged
);
  logic [IN_WORDS-1:0][DATA_WIDTH-1:0] pack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            pack <= '0;
    else if (clr)                          pack <= '0;
    else if (wr && beat_cnt == BW'(SLOT))  pack <= in_data;
  end

  // Slots behind the current beat come from pack, the current slot from the
  // live beat, and everything past it is zero padding.
  always_comb begin
    merged = '0;
    if (beat_cnt > BW'(SLOT))       merged = pack;
    else if (beat_cnt == BW'(SLOT)) merged = in_data;
  end
endmodule

module set_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int IN_WORDS    = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_WORDS-1:0][DATA_WIDTH-1:0]    in_data,
  input  logic                                   in_last,
  input  logic                                   buf_full,
  output logic                                   wen,
  output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_data,
  output logic [$clog2(DATA_OF_SET+1)-1:0]       set_words,
  output logic [CNT_WIDTH-1:0]                   sets_sent,
  output logic                                   busy
);
  localparam int BEATS = DATA_OF_SET / IN_WORDS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = $clog2(DATA_OF_SET + 1);

  logic                                         stage_valid;
  logic [BW-1:0]                                beat_cnt;
  logic [BEATS-1:0][IN_WORDS-1:0][DATA_WIDTH-1:0] merged, stage_q;
  logic                                         accept, complete;

  assign in_ready = rst_n && (!stage_valid || !buf_full);
  assign wen      = stage_valid && !buf_full;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((beat_cnt == BW'(BEATS-1)) || in_last);
  assign busy     = stage_valid || (beat_cnt != '0);
  assign set_data = stage_q;

  for (genvar b = 0; b < BEATS; b++) begin : g_slot
    set_packer_slot #(
      .SLOT(b), .BW(BW), .IN_WORDS(IN_WORDS), .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (accept && !complete),
      .clr      (complete),
      .beat_cnt (beat_cnt),
      .in_data  (in_data),
      .merged   (merged[b])
    );
  end

  // A completing beat on a drain edge reloads the stage, so stage_valid stays up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      beat_cnt    <= '0;
      stage_q     <= '0;
      set_words   <= '0;
      sets_sent   <= '0;
    end else begin
      if (complete) begin
        stage_valid <= 1'b1;
        stage_q     <= merged;
        set_words   <= SW'((int'(beat_cnt) + 1) * IN_WORDS);
        beat_cnt    <= '0;
      end else begin
        if (wen)    stage_valid <= 1'b0;
        if (accept) beat_cnt    <= beat_cnt + BW'(1);
      end
      if (wen) sets_sent <= sets_sent + CNT_WIDTH'(1);
    end
  end
endmodule
